// File: rtl/mem_access_unit.sv
// MEM-stage controller: drives a word-wide DataMemory port, extracts and extends sub-word
// loads, and turns byte/half stores into a stalled two-cycle read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        In_Valid,
  input  logic        In_MemRead,
  input  logic        In_MemWrite,
  input  logic [1:0]  In_Size,
  input  logic        In_Unsigned,
  input  logic [31:0] In_Address,
  input  logic [31:0] In_StoreData,
  input  logic        In_RegWrite,
  input  logic [4:0]  In_WriteReg,
  output logic        Stall,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  output logic        Mem_MemWrite,
  output logic        Mem_MemRead,
  input  logic [31:0] Mem_ReadData,
  output logic        Out_Valid,
  output logic        Out_RegWrite,
  output logic [4:0]  Out_WriteReg,
  output logic [31:0] Out_WBData,
  output logic        Out_Err
);

  typedef enum logic {StIdle, StWrite} stateT;

  stateT       stateQ, stateD;
  logic [31:0] rmwAddrQ, rmwAddrD;
  logic [31:0] mergedQ, mergedD;
  logic        outValidQ, outValidD;
  logic        outRegWriteQ, outRegWriteD;
  logic [4:0]  outWriteRegQ, outWriteRegD;
  logic [31:0] outWBDataQ, outWBDataD;
  logic        outErrQ, outErrD;

  logic        stallC, memWeC, memReC;
  logic [31:0] memAddrC, memWDataC;

  logic        isMemOp, sizeBad, alignBad, rangeBad, accErr;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadData, mergedWord;

  assign isMemOp  = In_MemRead | In_MemWrite;
  assign sizeBad  = (In_Size == 2'b11);
  assign alignBad = ((In_Size == 2'b01) && In_Address[0]) ||
                    ((In_Size == 2'b10) && (In_Address[1:0] != 2'b00));
  assign rangeBad = (In_Address >= MEM_BYTES);
  assign accErr   = In_Valid && isMemOp &&
                    (sizeBad || alignBad || rangeBad || (In_MemRead && In_MemWrite));

  assign laneByte = Mem_ReadData[{In_Address[1:0], 3'b000} +: 8];
  assign laneHalf = Mem_ReadData[{In_Address[1], 4'b0000} +: 16];

  always_comb begin
    loadData = Mem_ReadData;
    case (In_Size)
      2'b00:   loadData = In_Unsigned ? {24'b0, laneByte} : {{24{laneByte[7]}}, laneByte};
      2'b01:   loadData = In_Unsigned ? {16'b0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
      default: loadData = Mem_ReadData;
    endcase
  end

  // Old word with only the addressed lane replaced by the store data.
  always_comb begin
    mergedWord = Mem_ReadData;
    if (In_Size == 2'b00) begin
      mergedWord[{In_Address[1:0], 3'b000} +: 8] = In_StoreData[7:0];
    end else begin
      mergedWord[{In_Address[1], 4'b0000} +: 16] = In_StoreData[15:0];
    end
  end

  always_comb begin
    stateD       = stateQ;
    stallC       = 1'b0;
    memAddrC     = {In_Address[31:2], 2'b00};
    memWDataC    = In_StoreData;
    memWeC       = 1'b0;
    memReC       = 1'b0;
    rmwAddrD     = rmwAddrQ;
    mergedD      = mergedQ;
    outValidD    = 1'b0;
    outRegWriteD = 1'b0;
    outWriteRegD = outWriteRegQ;
    outWBDataD   = outWBDataQ;
    outErrD      = 1'b0;
    case (stateQ)
      StIdle: begin
        if (In_Valid) begin
          outValidD    = 1'b1;
          outWriteRegD = In_WriteReg;
          outWBDataD   = In_Address;
          if (accErr) begin
            outErrD = 1'b1;
          end else if (In_MemRead) begin
            memReC       = 1'b1;
            outRegWriteD = In_RegWrite;
            outWBDataD   = loadData;
          end else if (In_MemWrite) begin
            if (In_Size == 2'b10) begin
              memWeC = 1'b1;
            end else begin
              memReC    = 1'b1;
              stallC    = 1'b1;
              rmwAddrD  = {In_Address[31:2], 2'b00};
              mergedD   = mergedWord;
              outValidD = 1'b0;
              stateD    = StWrite;
            end
          end else begin
            outRegWriteD = In_RegWrite;
          end
        end
      end
      StWrite: begin
        memAddrC  = rmwAddrQ;
        memWDataC = mergedQ;
        memWeC    = 1'b1;
        outValidD = 1'b1;
        stateD    = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ       <= StIdle;
      rmwAddrQ     <= '0;
      mergedQ      <= '0;
      outValidQ    <= 1'b0;
      outRegWriteQ <= 1'b0;
      outWriteRegQ <= '0;
      outWBDataQ   <= '0;
      outErrQ      <= 1'b0;
    end else begin
      stateQ       <= stateD;
      rmwAddrQ     <= rmwAddrD;
      mergedQ      <= mergedD;
      outValidQ    <= outValidD;
      outRegWriteQ <= outRegWriteD;
      outWriteRegQ <= outWriteRegD;
      outWBDataQ   <= outWBDataD;
      outErrQ      <= outErrD;
    end
  end

  // Gating with Reset_n drops a pending RMW write the moment reset asserts.
  assign Stall         = stallC & Reset_n;
  assign Mem_MemWrite  = memWeC & Reset_n;
  assign Mem_MemRead   = memReC & Reset_n;
  assign Mem_Address   = Reset_n ? memAddrC : 32'b0;
  assign Mem_WriteData = Reset_n ? memWDataC : 32'b0;

  assign Out_Valid    = outValidQ;
  assign Out_RegWrite = outRegWriteQ;
  assign Out_WriteReg = outWriteRegQ;
  assign Out_WBData   = outWBDataQ;
  assign Out_Err      = outErrQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word-wide DataMemory stand-in plus a byte-array reference
// model; directed scenarios followed by randomized traffic.
module tb_mem_access_unit;

  localparam int unsigned MemBytes = 4096;

  logic        Clk, Reset_n;
  logic        In_Valid, In_MemRead, In_MemWrite, In_Unsigned, In_RegWrite;
  logic [1:0]  In_Size;
  logic [31:0] In_Address, In_StoreData;
  logic [4:0]  In_WriteReg;
  logic        Stall, Mem_MemWrite, Mem_MemRead;
  logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic        Out_Valid, Out_RegWrite, Out_Err;
  logic [4:0]  Out_WriteReg;
  logic [31:0] Out_WBData;

  mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_MemRead(In_MemRead),
    .In_MemWrite(In_MemWrite), .In_Size(In_Size), .In_Unsigned(In_Unsigned),
    .In_Address(In_Address), .In_StoreData(In_StoreData), .In_RegWrite(In_RegWrite),
    .In_WriteReg(In_WriteReg), .Stall(Stall), .Mem_Address(Mem_Address),
    .Mem_WriteData(Mem_WriteData), .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead),
    .Mem_ReadData(Mem_ReadData), .Out_Valid(Out_Valid), .Out_RegWrite(Out_RegWrite),
    .Out_WriteReg(Out_WriteReg), .Out_WBData(Out_WBData), .Out_Err(Out_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DataMemory stand-in: combinational read, word write on posedge.
  logic [31:0] dmem [0:MemBytes/4-1];
  logic        memClear;
  assign Mem_ReadData = dmem[Mem_Address[11:2]];
  always @(posedge Clk) begin
    if (memClear) begin
      for (int w = 0; w < MemBytes / 4; w++) dmem[w] <= 32'b0;
    end else if (Mem_MemWrite) begin
      dmem[Mem_Address[11:2]] <= Mem_WriteData;
    end
  end

  logic [7:0] refMem [0:MemBytes-1];
  int checks = 0;
  int errors = 0;

  logic        eErr, eStall;
  logic [31:0] eWB;
  logic        opStall, opRd, opWr, wStall, wWr, bValid;
  logic        oValid, oRegWrite, oErr;
  logic [4:0]  oWriteReg;
  logic [31:0] oWBData;

  initial begin
    #2_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  // Byte-level reference: what the access should return and how memory should change.
  task automatic model(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    eErr = (rd || wr) && (sz == 2'd3 || (rd && wr) || (addr % n) != 0 || addr >= MemBytes);
    eStall = 1'b0;
    eWB = addr;
    if (eErr) return;
    if (rd) begin
      eWB = 32'b0;
      for (int i = 0; i < n; i++) eWB = eWB | (32'(refMem[addr + i]) << (8 * i));
      if (!uns && n < 4 && eWB[8 * n - 1]) eWB = eWB | (32'hFFFF_FFFF << (8 * n));
    end else if (wr) begin
      for (int i = 0; i < n; i++) refMem[addr + i] = 8'(data >> (8 * i));
      eStall = (n < 4);
    end
  endtask

  // Called at a negedge; returns at a negedge with the slot idle.
  task automatic runOp(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, input logic rw,
                       input logic [4:0] wreg);
    In_Valid = 1'b1; In_MemRead = rd; In_MemWrite = wr; In_Size = sz; In_Unsigned = uns;
    In_Address = addr; In_StoreData = data; In_RegWrite = rw; In_WriteReg = wreg;
    #1;
    opStall = Stall; opRd = Mem_MemRead; opWr = Mem_MemWrite;
    wStall = 1'b0; wWr = 1'b0; bValid = 1'b0;
    @(posedge Clk); #1;
    if (opStall) begin
      wStall = Stall; wWr = Mem_MemWrite; bValid = Out_Valid;
      @(posedge Clk); #1;
    end
    oValid = Out_Valid; oRegWrite = Out_RegWrite; oWriteReg = Out_WriteReg;
    oWBData = Out_WBData; oErr = Out_Err;
    @(negedge Clk);
    In_Valid = 1'b0; In_MemRead = 1'b0; In_MemWrite = 1'b0;
  endtask

  task automatic doOp(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] data, input logic rw,
                      input logic [4:0] wreg);
    model(rd, wr, sz, uns, addr, data);
    runOp(rd, wr, sz, uns, addr, data, rw, wreg);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; memClear = 1'b1;
    In_Valid = 1'b1; In_MemRead = 1'b0; In_MemWrite = 1'b1; In_Size = 2'b10;
    In_Unsigned = 1'b0; In_Address = 32'h10; In_StoreData = 32'hDEAD_BEEF;
    In_RegWrite = 1'b1; In_WriteReg = 5'd3;
    for (int i = 0; i < MemBytes; i++) refMem[i] = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({Out_Valid, Out_RegWrite, Out_Err, Out_WriteReg, Out_WBData} !== 40'b0) begin
      errors++; $display("FAIL reset_out got %b%b%b %h %h want all zero", Out_Valid,
                         Out_RegWrite, Out_Err, Out_WriteReg, Out_WBData);
    end
    checks++;
    if ({Stall, Mem_MemWrite, Mem_MemRead, Mem_Address, Mem_WriteData} !== 67'b0) begin
      errors++; $display("FAIL reset_mem got %b%b%b %h %h want all zero", Stall,
                         Mem_MemWrite, Mem_MemRead, Mem_Address, Mem_WriteData);
    end
    @(negedge Clk);
    In_Valid = 1'b0; In_MemWrite = 1'b0;
    Reset_n = 1'b1; memClear = 1'b0;
  endtask

  task automatic test_word();
    doOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_0004, 1'b0, 5'd0);
    checks++;
    if (opStall !== 1'b0 || opWr !== 1'b1) begin
      errors++; $display("FAIL sw_strobe got stall=%b we=%b want stall=0 we=1", opStall, opWr);
    end
    doOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7);
    checks++;
    if (opStall !== 1'b0 || oWBData !== 32'h0000_0004 || oRegWrite !== 1'b1) begin
      errors++; $display("FAIL lw_data got stall=%b data=%h rw=%b want 0 00000004 1",
                         opStall, oWBData, oRegWrite);
    end
  endtask

  task automatic test_subword();
    doOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, 1'b0, 5'd0);
    doOp(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 1'b0, 5'd0);
    checks++;
    if (opStall !== 1'b1 || wStall !== 1'b0 || wWr !== 1'b1 || bValid !== 1'b0) begin
      errors++; $display("FAIL sb_rmw got stall=%b%b we=%b bubble=%b want 10 1 0",
                         opStall, wStall, wWr, bValid);
    end
    checks++;
    if (oValid !== 1'b1 || oRegWrite !== 1'b0) begin
      errors++; $display("FAIL sb_done got valid=%b rw=%b want 1 0", oValid, oRegWrite);
    end
    checks++;
    if (dmem[1] !== 32'h1122_AB44) begin
      errors++; $display("FAIL sb_word got %h want 1122ab44", dmem[1]);
    end
    doOp(1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1'b1, 5'd1);
    checks++;
    if (oWBData !== 32'hFFFF_FFAB) begin
      errors++; $display("FAIL lb got %h want ffffffab", oWBData);
    end
    doOp(1'b1, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 1'b1, 5'd1);
    checks++;
    if (oWBData !== 32'h0000_00AB) begin
      errors++; $display("FAIL lbu got %h want 000000ab", oWBData);
    end
    doOp(1'b0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_8001, 1'b0, 5'd0);
    checks++;
    if (dmem[1] !== 32'h8001_AB44 || opStall !== 1'b1) begin
      errors++; $display("FAIL sh_word got %h stall=%b want 8001ab44 1", dmem[1], opStall);
    end
    doOp(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 1'b1, 5'd2);
    checks++;
    if (oWBData !== 32'hFFFF_8001) begin
      errors++; $display("FAIL lh got %h want ffff8001", oWBData);
    end
    doOp(1'b1, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 1'b1, 5'd2);
    checks++;
    if (oWBData !== 32'h0000_8001) begin
      errors++; $display("FAIL lhu got %h want 00008001", oWBData);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    logic        isWr  [3];
    addrs = '{32'h2, 32'h5, MemBytes};
    sizes = '{2'b10, 2'b01, 2'b10};
    isWr  = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      doOp(!isWr[k], isWr[k], sizes[k], 1'b0, addrs[k], 32'hFFFF_FFFF, 1'b1, 5'd4);
      checks++;
      if (opRd !== 1'b0 || opWr !== 1'b0 || opStall !== 1'b0) begin
        errors++; $display("FAIL err_strobe[%0d] got rd=%b we=%b stall=%b want 0 0 0",
                           k, opRd, opWr, opStall);
      end
      checks++;
      if (oErr !== 1'b1 || oValid !== 1'b1 || oRegWrite !== 1'b0) begin
        errors++; $display("FAIL err_out[%0d] got err=%b valid=%b rw=%b want 1 1 0",
                           k, oErr, oValid, oRegWrite);
      end
      @(posedge Clk); #1;
      checks++;
      if (Out_Err !== 1'b0 || Out_Valid !== 1'b0) begin
        errors++; $display("FAIL err_pulse[%0d] got err=%b valid=%b want 0 0",
                           k, Out_Err, Out_Valid);
      end
      @(negedge Clk);
    end
    checks++;
    if (dmem[1] !== 32'h8001_AB44) begin
      errors++; $display("FAIL err_mem got %h want 8001ab44", dmem[1]);
    end
  endtask

  task automatic test_reset_in_write();
    doOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFE_F00D, 1'b0, 5'd0);
    In_Valid = 1'b1; In_MemRead = 1'b0; In_MemWrite = 1'b1; In_Size = 2'b00;
    In_Address = 32'h9; In_StoreData = 32'h55;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++; $display("FAIL rst_wr_stall got %b want 1", Stall);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Mem_MemWrite !== 1'b0 || Out_Valid !== 1'b0 || Out_WBData !== 32'b0 || Stall !== 1'b0)
    begin
      errors++; $display("FAIL rst_wr_out got we=%b valid=%b wb=%h stall=%b want 0 0 0 0",
                         Mem_MemWrite, Out_Valid, Out_WBData, Stall);
    end
    @(negedge Clk);
    In_Valid = 1'b0; In_MemWrite = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    checks++;
    if (dmem[2] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rst_wr_mem got %h want cafef00d", dmem[2]);
    end
    doOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 5'd5);
    checks++;
    if (opStall !== 1'b0 || opWr !== 1'b0 || oWBData !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rst_wr_idle got stall=%b we=%b data=%h want 0 0 cafef00d",
                         opStall, opWr, oWBData);
    end
  endtask

  task automatic test_passthrough();
    doOp(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd9);
    checks++;
    if (oWBData !== 32'h0000_1234 || oWriteReg !== 5'd9 || oRegWrite !== 1'b1 ||
        oErr !== 1'b0 || opRd !== 1'b0 || opWr !== 1'b0) begin
      errors++; $display("FAIL passthru got wb=%h wr=%0d rw=%b err=%b rd=%b we=%b want 1234 9 1 0 0 0",
                         oWBData, oWriteReg, oRegWrite, oErr, opRd, opWr);
    end
  endtask

  task automatic test_random();
    logic        rd, wr, uns, rw;
    logic [1:0]  sz;
    logic [31:0] addr, data;
    logic [4:0]  wreg;
    int          pick;
    for (int t = 0; t < 300; t++) begin
      pick = $urandom_range(0, 15);
      rd = (pick < 6) || (pick == 15);
      wr = (pick >= 6 && pick < 12) || (pick == 15);
      pick = $urandom_range(0, 15);
      sz = (pick == 0) ? 2'b11 : 2'(pick % 3);
      pick = $urandom_range(0, 19);
      addr = 32'($urandom_range(0, 63));
      if (pick < 18) addr = addr & ((sz == 2'b00) ? 32'hFFFF_FFFF :
                                    (sz == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
      if (pick == 19) addr = MemBytes + 32'($urandom_range(0, 64));
      uns = 1'($urandom); rw = 1'($urandom); wreg = 5'($urandom); data = $urandom;
      doOp(rd, wr, sz, uns, addr, data, rw, wreg);
      checks++;
      if (opStall !== eStall || oErr !== eErr || oValid !== 1'b1) begin
        errors++; $display("FAIL rnd_ctl[%0d] got stall=%b err=%b valid=%b want %b %b 1",
                           t, opStall, oErr, oValid, eStall, eErr);
      end
      if (eErr || !wr) begin
        checks++;
        if (oRegWrite !== (rw && !eErr) || oWriteReg !== wreg) begin
          errors++; $display("FAIL rnd_rw[%0d] got rw=%b reg=%0d want %b %0d",
                             t, oRegWrite, oWriteReg, rw && !eErr, wreg);
        end
      end
      if (!eErr && !wr) begin
        checks++;
        if (oWBData !== eWB) begin
          errors++; $display("FAIL rnd_wb[%0d] got %h want %h", t, oWBData, eWB);
        end
      end
      if (eErr) begin
        checks++;
        if (opRd !== 1'b0 || opWr !== 1'b0) begin
          errors++; $display("FAIL rnd_errstrobe[%0d] got rd=%b we=%b want 0 0", t, opRd, opWr);
        end
      end
      if (eStall) begin
        checks++;
        if (wStall !== 1'b0 || wWr !== 1'b1 || oRegWrite !== 1'b0) begin
          errors++; $display("FAIL rnd_rmw[%0d] got stall2=%b we=%b rw=%b want 0 1 0",
                             t, wStall, wWr, oRegWrite);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        @(posedge Clk); #1;
        checks++;
        if (Out_Valid !== 1'b0 || Out_RegWrite !== 1'b0 || Out_Err !== 1'b0) begin
          errors++; $display("FAIL rnd_idle[%0d] got %b%b%b want 000",
                             t, Out_Valid, Out_RegWrite, Out_Err);
        end
        @(negedge Clk);
      end
    end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (dmem[w] !== {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]}) begin
        errors++; $display("FAIL rnd_mem[%0d] got %h want %h", w, dmem[w],
                           {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_reset_in_write();
    test_passthrough();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
